// File: rtl/column_pair_feeder.sv
// Turns a row-major {high, low} stream into {odd, even} column pairs for the column DWT.
// Even rows go into a line buffer. Each beat of the following odd row is emitted as an L pair, then an H pair.
module column_pair_feeder #(
    parameter int DataWidth       = 16,
    parameter int MaximumSideSize = 512
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    output logic                   s_ready_o,
    input  logic                   s_valid_i,
    input  logic                   s_sof_i,
    input  logic                   s_eol_i,
    input  logic [2*DataWidth-1:0] s_data_i,
    input  logic                   m_ready_i,
    output logic                   m_valid_o,
    output logic                   m_sof_o,
    output logic                   m_eol_o,
    output logic [2*DataWidth-1:0] m_data_o,
    output logic                   err_o
);
    localparam int Depth = MaximumSideSize / 2;
    localparam int CntW  = $clog2(Depth + 1);
    localparam int AddrW = (Depth > 1) ? $clog2(Depth) : 1;

    typedef enum logic [1:0] {IDLE, LOW, HIGH} out_state_t;
    typedef enum logic {EVEN, ODD} phase_t;

    logic [2*DataWidth-1:0] line_buf [Depth];
    logic [2*DataWidth-1:0] rd_word;
    phase_t                 row_phase;
    out_state_t             out_state;
    logic [CntW-1:0]        wr_cnt, len, wr_idx;
    logic [AddrW-1:0]       addr;
    logic                   pend_sof, pend_eol;
    logic [DataWidth-1:0]   odd_hi, even_hi;
    logic                   accept, even_beat, odd_beat, out_fire;

    assign s_ready_o = (row_phase == EVEN) || (out_state == IDLE) ||
                       (out_state == HIGH && m_ready_i);
    assign accept    = s_valid_i && s_ready_o;
    // A sof always starts a fresh even row, even if it arrives where an odd row was expected.
    assign even_beat = accept && (row_phase == EVEN || s_sof_i);
    assign odd_beat  = accept && row_phase == ODD && !s_sof_i;
    assign out_fire  = m_valid_o && m_ready_i;
    assign wr_idx    = s_sof_i ? '0 : wr_cnt;
    assign addr      = wr_idx[AddrW-1:0];
    assign rd_word   = line_buf[addr];

    always_ff @(posedge clk_i) begin
        if (rst_ni && even_beat)
            line_buf[addr] <= s_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            row_phase <= EVEN;
            out_state <= IDLE;
            wr_cnt    <= '0;
            len       <= '0;
            pend_sof  <= 1'b0;
            pend_eol  <= 1'b0;
            odd_hi    <= '0;
            even_hi   <= '0;
            m_valid_o <= 1'b0;
            m_sof_o   <= 1'b0;
            m_eol_o   <= 1'b0;
            m_data_o  <= '0;
            err_o     <= 1'b0;
        end else begin
            // Odd beats are only accepted from IDLE or a completing HIGH, so they take priority.
            if (odd_beat) begin
                out_state <= LOW;
                m_valid_o <= 1'b1;
                m_data_o  <= {s_data_i[DataWidth-1:0], rd_word[DataWidth-1:0]};
                m_sof_o   <= pend_sof;
                m_eol_o   <= 1'b0;
                odd_hi    <= s_data_i[2*DataWidth-1:DataWidth];
                even_hi   <= rd_word[2*DataWidth-1:DataWidth];
                pend_eol  <= s_eol_i;
            end else if (out_fire) begin
                if (out_state == LOW) begin
                    out_state <= HIGH;
                    m_data_o  <= {odd_hi, even_hi};
                    m_sof_o   <= 1'b0;
                    m_eol_o   <= pend_eol;
                    pend_sof  <= 1'b0;
                end else begin
                    out_state <= IDLE;
                    m_valid_o <= 1'b0;
                    m_sof_o   <= 1'b0;
                    m_eol_o   <= 1'b0;
                end
            end

            if (even_beat) begin
                if (wr_idx == '0)
                    pend_sof <= s_sof_i;
                if (row_phase == ODD)
                    err_o <= 1'b1;
                row_phase <= s_eol_i ? ODD : EVEN;
                if (s_eol_i) begin
                    len    <= wr_idx + CntW'(1);
                    wr_cnt <= '0;
                end else begin
                    wr_cnt <= wr_idx + CntW'(1);
                end
            end else if (odd_beat) begin
                if (s_eol_i) begin
                    wr_cnt    <= '0;
                    row_phase <= EVEN;
                    if (wr_cnt + CntW'(1) != len)
                        err_o <= 1'b1;
                end else begin
                    wr_cnt <= wr_cnt + CntW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_column_pair_feeder.sv
// Directed bench for column_pair_feeder. A queue scoreboard holds the expected column pairs
// in the order the stimulus implies, and each output handshake is compared against it.
module tb_column_pair_feeder;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        s_ready_o, s_valid_i, s_sof_i, s_eol_i;
    logic [31:0] s_data_i;
    logic        m_ready_i, m_valid_o, m_sof_o, m_eol_o;
    logic [31:0] m_data_o;
    logic        err_o;

    column_pair_feeder #(.DataWidth(16), .MaximumSideSize(512)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .s_ready_o(s_ready_o), .s_valid_i(s_valid_i), .s_sof_i(s_sof_i),
        .s_eol_i(s_eol_i), .s_data_i(s_data_i),
        .m_ready_i(m_ready_i), .m_valid_o(m_valid_o), .m_sof_o(m_sof_o),
        .m_eol_o(m_eol_o), .m_data_o(m_data_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int          compared = 0;
    int          mismatched = 0;
    int          out_cnt = 0;
    int          eol_cnt = 0;
    logic [33:0] exp_q[$];
    logic [31:0] even_row [256];
    logic        model_sof = 1'b0;
    int          waits [256];
    logic        err_pre;
    bit          bp_random = 1'b0;
    logic        ready_hold = 1'b1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] gen(input int r, input int k);
        logic [15:0] lo, hi;
        lo = 16'(r * 32 + k);
        hi = 16'(r * 32 + 16 + k);
        return {hi, lo};
    endfunction

    always @(posedge clk_i) begin
        #1;
        m_ready_i = bp_random ? 1'($urandom_range(0, 1)) : ready_hold;
    end

    always @(negedge clk_i) begin
        if (rst_ni && m_valid_o && m_ready_i) begin
            out_cnt++;
            if (m_eol_o) eol_cnt++;
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $error("FAIL sb_underflow observed=%0h expected=none", {m_data_o, m_sof_o, m_eol_o});
            end else begin
                check("out_beat", 64'({m_data_o, m_sof_o, m_eol_o}), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic send_beat(input logic [31:0] d, input logic sof, input logic eol, output int w);
        logic acc;
        s_valid_i = 1'b1; s_data_i = d; s_sof_i = sof; s_eol_i = eol;
        w = 0;
        forever begin
            @(negedge clk_i);
            acc = s_ready_o;
            @(posedge clk_i);
            if (acc) break;
            w++;
            if (w > 5000) begin
                compared++;
                mismatched++;
                $error("FAIL accept_timeout observed=%0d expected=<5000", w);
                break;
            end
        end
        #1;
        s_valid_i = 1'b0; s_sof_i = 1'b0; s_eol_i = 1'b0;
    endtask

    task automatic send_row(input int r, input int n, input logic sof, input bit is_odd, input bit eol_last);
        logic [31:0] d;
        logic        last;
        for (int k = 0; k < n; k++) begin
            d    = gen(r, k);
            last = (k == n - 1) && eol_last;
            if (!is_odd) begin
                even_row[k] = d;
                if (k == 0) model_sof = sof;
            end else begin
                exp_q.push_back({d[15:0], even_row[k][15:0], model_sof, 1'b0});
                exp_q.push_back({d[31:16], even_row[k][31:16], 1'b0, last});
                model_sof = 1'b0;
            end
            if (k == n - 1) err_pre = err_o;
            send_beat(d, sof && k == 0, last, waits[k]);
        end
    endtask

    task automatic drain(input string tag);
        int i = 0;
        while (exp_q.size() != 0 && i < 20000) begin
            @(posedge clk_i);
            i++;
        end
        repeat (4) @(posedge clk_i);
        #1;
        check({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        exp_q.delete();
        model_sof = 1'b0;
    endtask

    initial begin
        logic [31:0] snap;
        rst_ni = 1'b0; s_valid_i = 1'b0; s_sof_i = 1'b0; s_eol_i = 1'b0;
        s_data_i = '0; m_ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(negedge clk_i);
        check("rst_valid", 64'(m_valid_o), 64'd0);
        check("rst_sof",   64'(m_sof_o),   64'd0);
        check("rst_eol",   64'(m_eol_o),   64'd0);
        check("rst_data",  64'(m_data_o),  64'd0);
        check("rst_err",   64'(err_o),     64'd0);
        check("rst_ready", 64'(s_ready_o), 64'd1);
        @(posedge clk_i); #1;

        // 1: basic 4-beat frame, ready always high
        out_cnt = 0; eol_cnt = 0;
        send_row(0, 4, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) check("s1_even_wait", 64'(waits[k]), 64'd0);
        send_row(1, 4, 1'b0, 1'b1, 1'b1);
        check("s1_odd_wait0", 64'(waits[0]), 64'd0);
        for (int k = 1; k < 4; k++) check("s1_odd_wait", 64'(waits[k]), 64'd1);
        drain("s1");
        check("s1_count", 64'(out_cnt), 64'd8);
        check("s1_eols",  64'(eol_cnt), 64'd1);
        check("s1_err",   64'(err_o),   64'd0);

        // 2: three-cycle output stall mid odd row
        out_cnt = 0;
        send_row(0, 4, 1'b1, 1'b0, 1'b1);
        fork
            send_row(1, 4, 1'b0, 1'b1, 1'b1);
            begin
                repeat (3) @(posedge clk_i);
                ready_hold = 1'b0;
                @(negedge clk_i);
                snap = m_data_o;
                for (int c = 0; c < 3; c++) begin
                    if (c > 0) @(negedge clk_i);
                    check("s2_stall_valid", 64'(m_valid_o), 64'd1);
                    check("s2_stall_data",  64'(m_data_o),  64'(snap));
                    check("s2_stall_ready", 64'(s_ready_o), 64'd0);
                end
                ready_hold = 1'b1;
            end
        join
        drain("s2");
        check("s2_count", 64'(out_cnt), 64'd8);

        // 3: short odd row
        out_cnt = 0; eol_cnt = 0;
        send_row(0, 4, 1'b1, 1'b0, 1'b1);
        send_row(1, 3, 1'b0, 1'b1, 1'b1);
        check("s3_err_before_eol", 64'(err_pre), 64'd0);
        check("s3_err_after_eol",  64'(err_o),   64'd1);
        drain("s3");
        check("s3_count", 64'(out_cnt), 64'd6);
        check("s3_eols",  64'(eol_cnt), 64'd1);
        check("s3_err_sticky", 64'(err_o), 64'd1);
        do_reset();

        // 4: sof where row1 was expected restarts the frame
        out_cnt = 0;
        send_row(0, 4, 1'b1, 1'b0, 1'b1);
        send_row(2, 4, 1'b1, 1'b0, 1'b1);
        check("s4_err", 64'(err_o), 64'd1);
        send_row(3, 4, 1'b0, 1'b1, 1'b1);
        drain("s4");
        check("s4_count", 64'(out_cnt), 64'd8);

        // 5: reset in the middle of an odd row, then a clean frame
        send_row(0, 4, 1'b1, 1'b0, 1'b1);
        send_row(1, 2, 1'b0, 1'b1, 1'b0);
        do_reset();
        @(negedge clk_i);
        check("s5_valid", 64'(m_valid_o), 64'd0);
        check("s5_ready", 64'(s_ready_o), 64'd1);
        check("s5_err",   64'(err_o),     64'd0);
        @(posedge clk_i); #1;
        out_cnt = 0; eol_cnt = 0;
        send_row(0, 4, 1'b1, 1'b0, 1'b1);
        send_row(1, 4, 1'b0, 1'b1, 1'b1);
        drain("s5");
        check("s5_count", 64'(out_cnt), 64'd8);
        check("s5_eols",  64'(eol_cnt), 64'd1);
        check("s5_err_end", 64'(err_o), 64'd0);

        // 6: full 256-beat rows with random backpressure
        out_cnt = 0; eol_cnt = 0;
        bp_random = 1'b1;
        send_row(256, 256, 1'b1, 1'b0, 1'b1);
        send_row(384, 256, 1'b0, 1'b1, 1'b1);
        drain("s6");
        bp_random = 1'b0;
        check("s6_count", 64'(out_cnt), 64'd512);
        check("s6_eols",  64'(eol_cnt), 64'd1);
        check("s6_err",   64'(err_o),   64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
